ss_accumulator: RTL and testbench

//  Streaming accumulator with a two-digit seven-segment readout.
//  - Sums NO_OF_STEPS consecutive unsigned samples, one per clock, into a frame total.
//  - Shows each completed frame total as two decimal digits on seven-segment patterns.
//  - Sits between a sample source and a 2-digit display driver; no handshake (sample every cycle).

---
 rtl/ss_accumulator.sv | 88 ++++++++
 tb/tb_ss_accumulator.sv | 127 ++++++++++++
 2 files changed

// File: rtl/ss_accumulator.sv
// Streaming frame accumulator: sums NO_OF_STEPS unsigned samples per frame and
// shows each completed frame total as two registered seven-segment digits.
module ss_accumulator #(
  parameter int WIDTH       = 3,
  parameter int NO_OF_STEPS = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [WIDTH-1:0]      s_data,
  output logic [1:0][6:0]       m_data
);

  localparam int MAX_TOTAL = NO_OF_STEPS * ((2 ** WIDTH) - 1);
  localparam int ACC_W     = WIDTH + $clog2(NO_OF_STEPS) + 1;
  localparam int CNT_W     = (NO_OF_STEPS > 1) ? $clog2(NO_OF_STEPS) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(NO_OF_STEPS - 1);
  localparam logic [6:0]       SEG_ZERO  = 7'h3F;

  // Two decimal digits are all the display can show.
  if (NO_OF_STEPS < 1) begin : g_bad_steps
    $error("ss_accumulator: NO_OF_STEPS must be at least 1");
  end
  if (MAX_TOTAL > 99) begin : g_bad_range
    $error("ss_accumulator: NO_OF_STEPS*(2**WIDTH-1) exceeds 99");
  end

  function automatic logic [6:0] seg7(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = 7'h3F;
      4'd1:    seg = 7'h06;
      4'd2:    seg = 7'h5B;
      4'd3:    seg = 7'h4F;
      4'd4:    seg = 7'h66;
      4'd5:    seg = 7'h6D;
      4'd6:    seg = 7'h7D;
      4'd7:    seg = 7'h07;
      4'd8:    seg = 7'h7F;
      4'd9:    seg = 7'h6F;
      default: seg = 7'h00;
    endcase
    return seg;
  endfunction

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0][6:0]  disp_q, disp_d;

  logic [ACC_W-1:0] total;
  logic [6:0]       total7;
  logic [3:0]       tens;
  logic [3:0]       ones;
  logic             frame_end;

  assign frame_end = (cnt_q == LAST_STEP);
  assign total     = acc_q + ACC_W'(s_data);
  assign total7    = 7'(total);
  assign tens      = 4'(total7 / 7'd10);
  assign ones      = 4'(total7 % 7'd10);

  // The closing sample goes straight into the display; the next frame starts from zero.
  always_comb begin
    acc_d  = total;
    cnt_d  = cnt_q + CNT_W'(1);
    disp_d = disp_q;
    if (frame_end) begin
      acc_d     = '0;
      cnt_d     = '0;
      disp_d[1] = seg7(tens);
      disp_d[0] = seg7(ones);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      disp_q <= {SEG_ZERO, SEG_ZERO};
    end else begin
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      disp_q <= disp_d;
    end
  end

  assign m_data = disp_q;

endmodule

// File: tb/tb_ss_accumulator.sv
// Bench for ss_accumulator: directed display scenarios followed by random
// back-to-back frames checked against a sample-list reference model.
module tb_ss_accumulator;

  localparam int W = 3;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rstn = 1'b0;
  logic [W-1:0]   s_data = '0;
  logic [1:0][6:0] m_data;

  int total = 0;
  int bad   = 0;

  // Reference model: samples of the open frame and the last shown total.
  int frame_q[$];
  int shown = 0;

  logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  ss_accumulator #(.WIDTH(W), .NO_OF_STEPS(N)) dut (
    .clk    (clk),
    .rstn   (rstn),
    .s_data (s_data),
    .m_data (m_data)
  );

  always #5 clk = ~clk;

  function automatic logic [13:0] enc(input int value);
    logic [13:0] r;
    r[13:7] = seg_tab[value / 10];
    r[6:0]  = seg_tab[value % 10];
    return r;
  endfunction

  task automatic check(input string tag, input logic [13:0] exp);
    total++;
    assert (m_data === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, m_data, exp);
    end
  endtask

  // One clock edge with the given inputs; model updated and DUT compared after the edge.
  task automatic step(input logic [W-1:0] d, input logic r);
    int sum;
    @(negedge clk);
    s_data = d;
    rstn   = r;
    @(posedge clk);
    if (!r) begin
      frame_q.delete();
      shown = 0;
    end else begin
      frame_q.push_back(int'(d));
      if (frame_q.size() == N) begin
        sum = 0;
        foreach (frame_q[i]) sum += frame_q[i];
        shown = sum;
        frame_q.delete();
      end
    end
    #1;
    check("model", enc(shown));
  endtask

  initial begin
    int sum;
    int s;

    // 1: reset held for two edges
    step(3'd5, 1'b0);
    step(3'd7, 1'b0);
    check("reset_00", {7'h3F, 7'h3F});

    // 2: 0,1,2,3 -> "06", display unchanged mid-frame
    step(3'd0, 1'b1); check("f1_e1", {7'h3F, 7'h3F});
    step(3'd1, 1'b1); check("f1_e2", {7'h3F, 7'h3F});
    step(3'd2, 1'b1); check("f1_e3", {7'h3F, 7'h3F});
    step(3'd3, 1'b1); check("f1_06", {7'h3F, 7'h7D});

    // 3: zeros -> "06" held, then "00"
    step(3'd0, 1'b1); check("hold1", {7'h3F, 7'h7D});
    step(3'd0, 1'b1); check("hold2", {7'h3F, 7'h7D});
    step(3'd0, 1'b1); check("hold3", {7'h3F, 7'h7D});
    step(3'd0, 1'b1); check("f2_00", {7'h3F, 7'h3F});

    // 4: max frame 28, then 09
    for (int i = 0; i < 4; i++) step(3'd7, 1'b1);
    check("f3_28", {7'h5B, 7'h7F});
    step(3'd5, 1'b1);
    step(3'd0, 1'b1);
    step(3'd0, 1'b1);
    step(3'd4, 1'b1);
    check("f4_09", {7'h3F, 7'h6F});

    // 5: reset mid-frame discards the partial sum
    step(3'd3, 1'b1);
    step(3'd3, 1'b1);
    step(3'd6, 1'b0);
    check("midrst_00", {7'h3F, 7'h3F});
    for (int i = 0; i < 3; i++) begin
      step(3'd1, 1'b1);
      check("post_rst_hold", {7'h3F, 7'h3F});
    end
    step(3'd1, 1'b1);
    check("f5_04", {7'h3F, 7'h66});

    // 6: random back-to-back frames, each total tallied independently here
    for (int f = 0; f < 500; f++) begin
      sum = 0;
      for (int k = 0; k < N; k++) begin
        s = int'($urandom_range(0, (1 << W) - 1));
        sum += s;
        step(W'(s), 1'b1);
      end
      check("rand_frame", enc(sum));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
